rv32_mod_fetch_aligner: RTL and testbench

RV32_MOD_FETCH_ALIGNER -- requirements
Module: rv32_mod_fetch_aligner

---
 rtl/rv32_mod_fetch_aligner.sv | 233 +++++++++++++++++++++++
 tb/tb_rv32_mod_fetch_aligner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_fetch_aligner.sv
// RV32 fetch aligner: fetches aligned 32-bit words and re-slices them into
// 16/32-bit instructions through a four-halfword queue, with flush/redirect.
module rv32_mod_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_HW   = {RESET_PC[31:1], 1'b0};
    localparam logic [31:0] RESET_FETCH   = {RESET_PC[31:2], 2'b00};

    logic [15:0] q_r [4];
    logic [2:0]  count_r;
    logic [31:0] pc_r;
    logic [31:0] fetch_addr_r;
    logic        skip_lo_r;
    state_t      state_r;

    logic        head_comp_s;
    logic        pop_s;
    logic        push_s;
    logic [2:0]  pop_n_s;
    logic [2:0]  cnt_pop_s;
    logic [2:0]  cnt_nxt_s;
    logic [15:0] q_pop_s [4];
    logic [15:0] q_nxt_s [4];
    logic [31:0] pc_nxt_s;
    logic        nxt_comp_s;
    logic        valid_nxt_s;
    logic [31:0] instr_nxt_s;
    logic [31:0] flush_hw_s;
    logic [31:0] flush_word_s;
    logic        flush_lsb_unused_s;

    assign flush_lsb_unused_s = flush_pc[0];
    assign flush_hw_s   = {flush_pc[31:1], 1'b0};
    assign flush_word_s = {flush_pc[31:2], 2'b00};

    assign head_comp_s = (q_r[0][1:0] != 2'b11);
    assign pop_s       = instr_valid & instr_ready & ~flush;
    assign push_s      = (state_r == ST_WAIT) & mem_ack & ~flush;
    assign pop_n_s     = pop_s ? (head_comp_s ? 3'd1 : 3'd2) : 3'd0;
    assign cnt_pop_s   = count_r - pop_n_s;

    // Shift out consumed halfwords, then append the fetched word behind the survivors.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            q_pop_s[i] = q_r[i];
            q_nxt_s[i] = q_r[i];
        end
        case (pop_n_s)
            3'd1: begin
                q_pop_s[0] = q_r[1];
                q_pop_s[1] = q_r[2];
                q_pop_s[2] = q_r[3];
                q_pop_s[3] = q_r[3];
            end
            3'd2: begin
                q_pop_s[0] = q_r[2];
                q_pop_s[1] = q_r[3];
                q_pop_s[2] = q_r[3];
                q_pop_s[3] = q_r[3];
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    q_pop_s[i] = q_r[i];
                end
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            q_nxt_s[i] = q_pop_s[i];
            if (push_s) begin
                if (skip_lo_r) begin
                    if (3'(i) == cnt_pop_s) begin
                        q_nxt_s[i] = mem_rdata[31:16];
                    end else begin
                        q_nxt_s[i] = q_pop_s[i];
                    end
                end else if (3'(i) == cnt_pop_s) begin
                    q_nxt_s[i] = mem_rdata[15:0];
                end else if (3'(i) == (cnt_pop_s + 3'd1)) begin
                    q_nxt_s[i] = mem_rdata[31:16];
                end else begin
                    q_nxt_s[i] = q_pop_s[i];
                end
            end else begin
                q_nxt_s[i] = q_pop_s[i];
            end
        end
    end

    // Next count, pc and the decoder-facing view of the next queue head.
    always_comb begin
        cnt_nxt_s = cnt_pop_s;
        pc_nxt_s  = pc_r;
        if (flush) begin
            cnt_nxt_s = 3'd0;
            pc_nxt_s  = flush_hw_s;
        end else begin
            if (push_s) begin
                cnt_nxt_s = cnt_pop_s + (skip_lo_r ? 3'd1 : 3'd2);
            end else begin
                cnt_nxt_s = cnt_pop_s;
            end
            if (pop_s) begin
                pc_nxt_s = pc_r + (head_comp_s ? 32'd2 : 32'd4);
            end else begin
                pc_nxt_s = pc_r;
            end
        end
        nxt_comp_s  = (q_nxt_s[0][1:0] != 2'b11);
        valid_nxt_s = (cnt_nxt_s >= 3'd2) || ((cnt_nxt_s == 3'd1) && nxt_comp_s);
        if (nxt_comp_s) begin
            instr_nxt_s = {16'h0000, q_nxt_s[0]};
        end else begin
            instr_nxt_s = {q_nxt_s[1], q_nxt_s[0]};
        end
    end

    // Queue, pc and registered decoder outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                q_r[i] <= 16'h0000;
            end
            count_r     <= 3'd0;
            pc_r        <= RESET_PC_HW;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= RESET_PC_HW;
        end else begin
            for (int i = 0; i < 4; i++) begin
                q_r[i] <= q_nxt_s[i];
            end
            count_r     <= cnt_nxt_s;
            pc_r        <= pc_nxt_s;
            instr_valid <= valid_nxt_s;
            instr       <= instr_nxt_s;
            instr_pc    <= pc_nxt_s;
        end
    end

    // Fetch FSM; a word requested before a flush is always drained and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_FETCH;
            fetch_addr_r <= RESET_FETCH;
            skip_lo_r    <= RESET_PC[1];
        end else begin
            if (flush) begin
                skip_lo_r <= flush_pc[1];
            end else if (push_s) begin
                skip_lo_r <= 1'b0;
            end else begin
                skip_lo_r <= skip_lo_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        state_r      <= ST_WAIT;
                        mem_req      <= 1'b1;
                        mem_addr     <= flush_word_s;
                        fetch_addr_r <= flush_word_s;
                    end else if (cnt_pop_s <= 3'd2) begin
                        state_r  <= ST_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr_r;
                    end else begin
                        state_r <= ST_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        fetch_addr_r <= flush_word_s;
                        if (mem_ack) begin
                            state_r <= ST_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state_r <= ST_DISCARD;
                            mem_req <= 1'b1;
                        end
                    end else if (mem_ack) begin
                        state_r      <= ST_IDLE;
                        mem_req      <= 1'b0;
                        fetch_addr_r <= fetch_addr_r + 32'd4;
                    end else begin
                        state_r <= ST_WAIT;
                        mem_req <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (flush) begin
                        fetch_addr_r <= flush_word_s;
                    end else begin
                        fetch_addr_r <= fetch_addr_r;
                    end
                    if (mem_ack) begin
                        state_r <= ST_IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state_r <= ST_DISCARD;
                        mem_req <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
// Directed bench for rv32_mod_fetch_aligner: hand sequences for reset, stall,
// flush and split instructions, then a table-driven instruction stream.
module tb_rv32_mod_fetch_aligner;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        auto_mem;
    logic        auto_ack;
    logic [31:0] auto_rdata;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic [31:0] mem [16];

    int checks;
    int errors;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;
    vec_t vecs [9];

    assign mem_ack   = auto_mem ? auto_ack : man_ack;
    assign mem_rdata = auto_mem ? auto_rdata : man_rdata;

    rv32_mod_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait memory: acknowledges one cycle of each request.
    initial begin
        auto_ack   = 1'b0;
        auto_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_req && !auto_ack) begin
                auto_ack   = 1'b1;
                auto_rdata = mem[mem_addr[5:2]];
            end else begin
                auto_ack = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid timeout actual=0 expected=1");
        end
    endtask

    initial begin
        bit ok;
        checks = 0;
        errors = 0;
        vecs[0] = '{pc: 32'h0000_0000, instr: 32'h0000_4501};
        vecs[1] = '{pc: 32'h0000_0002, instr: 32'h0000_4505};
        vecs[2] = '{pc: 32'h0000_0004, instr: 32'h0000_4501};
        vecs[3] = '{pc: 32'h0000_0006, instr: 32'h00A0_0093};
        vecs[4] = '{pc: 32'h0000_000A, instr: 32'h0020_0113};
        vecs[5] = '{pc: 32'h0000_000E, instr: 32'h0000_4509};
        vecs[6] = '{pc: 32'h0000_0010, instr: 32'h00A0_0093};
        vecs[7] = '{pc: 32'h0000_0014, instr: 32'h0000_4601};
        vecs[8] = '{pc: 32'h0000_0016, instr: 32'h0000_4581};
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h4505_4501;
        mem[1]  = 32'h0093_4501;
        mem[2]  = 32'h0113_00A0;
        mem[3]  = 32'h4509_0020;
        mem[4]  = 32'h00A0_0093;
        mem[5]  = 32'h4581_4601;
        mem[15] = 32'h4589_0000;

        auto_mem    = 1'b0;
        man_ack     = 1'b0;
        man_rdata   = 32'h0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);
        man_ack = 1'b1; man_rdata = 32'h00A0_0093;
        @(negedge clk);
        man_ack = 1'b0;
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_instr", instr, 32'h00A0_0093);
        check("first_pc", instr_pc, 32'h0);

        // Stall: queue fills to 4 then fetching stops
        @(negedge clk);
        check("refill_req", {31'd0, mem_req}, 32'd1);
        check("refill_addr", mem_addr, 32'h4);
        man_ack = 1'b1; man_rdata = 32'h4505_4501;
        @(negedge clk);
        man_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_req", {31'd0, mem_req}, 32'd0);
            check("stall_instr", instr, 32'h00A0_0093);
            check("stall_pc", instr_pc, 32'h0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("resume_instr", instr, 32'h0000_4501);
        check("resume_pc", instr_pc, 32'h4);
        check("resume_req", {31'd0, mem_req}, 32'd1);
        check("resume_addr", mem_addr, 32'h8);

        // Flush while waiting: stale word dropped, only upper halfword of new word kept
        flush = 1'b1; flush_pc = 32'h0000_0102;
        @(negedge clk);
        flush = 1'b0;
        check("disc_valid", {31'd0, instr_valid}, 32'd0);
        check("disc_req_held", {31'd0, mem_req}, 32'd1);
        check("disc_addr_held", mem_addr, 32'h8);
        man_ack = 1'b1; man_rdata = 32'h1111_2222;
        @(negedge clk);
        man_ack = 1'b0;
        check("stale_dropped", {31'd0, instr_valid}, 32'd0);
        check("stale_req_low", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("redir_req", {31'd0, mem_req}, 32'd1);
        check("redir_addr", mem_addr, 32'h100);
        man_ack = 1'b1; man_rdata = 32'h4585_FFFF;
        @(negedge clk);
        man_ack = 1'b0;
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_instr", instr, 32'h0000_4585);
        check("redir_pc", instr_pc, 32'h102);

        // Flush coincident with ack, then a 32-bit instruction split across words
        @(negedge clk);
        check("wait2_addr", mem_addr, 32'h104);
        flush = 1'b1; flush_pc = 32'h0000_0200;
        man_ack = 1'b1; man_rdata = 32'h4501_4501;
        @(negedge clk);
        flush = 1'b0; man_ack = 1'b0;
        check("flack_valid", {31'd0, instr_valid}, 32'd0);
        check("flack_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("flack_addr", mem_addr, 32'h200);
        man_ack = 1'b1; man_rdata = 32'h0093_4501;
        @(negedge clk);
        man_ack = 1'b0;
        check("split_c_instr", instr, 32'h0000_4501);
        check("split_c_pc", instr_pc, 32'h200);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("split_partial", {31'd0, instr_valid}, 32'd0);
        check("split_addr", mem_addr, 32'h204);
        man_ack = 1'b1; man_rdata = 32'h0113_00A0;
        @(negedge clk);
        man_ack = 1'b0;
        check("split_valid", {31'd0, instr_valid}, 32'd1);
        check("split_instr", instr, 32'h00A0_0093);
        check("split_pc", instr_pc, 32'h202);
        @(negedge clk);
        check("full3_req", {31'd0, mem_req}, 32'd0);
        flush = 1'b1; flush_pc = 32'h0000_0301;
        @(negedge clk);
        flush = 1'b0;
        check("idle_flush_req", {31'd0, mem_req}, 32'd1);
        check("idle_flush_addr", mem_addr, 32'h300);
        check("idle_flush_pc", instr_pc, 32'h300);

        // Reset during a pending request with ack pulses
        rst_n = 1'b0; man_ack = 1'b1; man_rdata = 32'h4501_4501;
        #1;
        check("rst_async_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            man_ack = ~man_ack;
            check("rstw_valid", {31'd0, instr_valid}, 32'd0);
            check("rstw_addr", mem_addr, 32'h0);
        end
        man_ack = 1'b0;
        rst_n = 1'b1;
        check("rstw_pc", instr_pc, 32'h0);
        @(negedge clk);
        check("rel_req", {31'd0, mem_req}, 32'd1);
        check("rel_addr", mem_addr, 32'h0);

        // Table-driven instruction stream from memory
        auto_mem = 1'b1;
        instr_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_valid(ok);
            if (!ok) break;
            check("vec_instr", instr, vecs[k].instr);
            check("vec_pc", instr_pc, vecs[k].pc);
            check("vec_align", {30'd0, mem_addr[1:0]}, 32'd0);
            @(negedge clk);
        end

        // Redirect to the top of the address space and wrap around
        flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        flush = 1'b0;
        wait_valid(ok);
        if (ok) begin
            check("wrap_hi_instr", instr, 32'h0000_4589);
            check("wrap_hi_pc", instr_pc, 32'hFFFF_FFFE);
            @(negedge clk);
            wait_valid(ok);
            if (ok) begin
                check("wrap_lo_instr", instr, 32'h0000_4501);
                check("wrap_lo_pc", instr_pc, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
